// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap sequencer:
// CSR addresses, interrupt cause codes, mstatus bit positions and FSM state.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Interrupt cause codes; the interrupt flag (MSB) is added by the arbiter.
  localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT   = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    IDLE, RD_STATUS, WR_EPC, WR_CAUSE, WR_TVAL, WR_STATUS, RD_TVEC, RD_EPC, REDIRECT
  } state_t;

  typedef enum logic {KIND_TRAP, KIND_MRET} kind_t;

endpackage

// File: rtl/trap_prio.sv
// Combinational event arbiter: picks exception > mret > external irq > timer irq
// and forms the epc/cause/tval values to latch when the sequencer accepts it.
module trap_prio
  import trap_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [PC_W-1:0] exc_pc,
  input  logic [PC_W-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [PC_W-1:0] retire_pc,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic            mstatus_mie,
  input  logic [1:0]      mie_mask,
  output logic            accept,
  output kind_t           kind,
  output logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] cause,
  output logic [PC_W-1:0] tval
);

  logic ext_pend;
  logic tmr_pend;

  assign ext_pend = irq_ext   & mie_mask[1] & mstatus_mie;
  assign tmr_pend = irq_timer & mie_mask[0] & mstatus_mie;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    accept = 1'b1;
    kind   = KIND_TRAP;
    epc    = retire_pc;
    cause  = '0;
    tval   = '0;
    if (exc_valid) begin
      epc   = exc_pc;
      cause = {{(PC_W-4){1'b0}}, exc_code};
      tval  = exc_tval;
    end else if (mret_valid) begin
      kind = KIND_MRET;
    end else if (ext_pend) begin
      cause = {1'b1, {(PC_W-5){1'b0}}, CAUSE_M_EXT};
    end else if (tmr_pend) begin
      cause = {1'b1, {(PC_W-5){1'b0}}, CAUSE_M_TIMER};
    end else begin
      accept = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: runs the CSR request/ack sequence for a trap or
// mret, stalls fetch while busy and ends with a one-cycle PC redirect.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [PC_W-1:0] exc_pc,
  input  logic [PC_W-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [PC_W-1:0] retire_pc,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic            mstatus_mie,
  input  logic [1:0]      mie_mask,
  output logic            stall,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            csr_req,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [PC_W-1:0] csr_wdata,
  input  logic            csr_ack,
  input  logic [PC_W-1:0] csr_rdata
);

  state_t          state;
  kind_t           kind_q;
  logic [PC_W-1:0] epc_q, cause_q, tval_q, status_q;

  logic            acc;
  kind_t           acc_kind;
  logic [PC_W-1:0] acc_epc, acc_cause, acc_tval;

  trap_prio #(.PC_W(PC_W)) u_prio (
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .exc_pc     (exc_pc),
    .exc_tval   (exc_tval),
    .mret_valid (mret_valid),
    .retire_pc  (retire_pc),
    .irq_timer  (irq_timer),
    .irq_ext    (irq_ext),
    .mstatus_mie(mstatus_mie),
    .mie_mask   (mie_mask),
    .accept     (acc),
    .kind       (acc_kind),
    .epc        (acc_epc),
    .cause      (acc_cause),
    .tval       (acc_tval)
  );

  function automatic logic [PC_W-1:0] next_status(kind_t k, logic [PC_W-1:0] s);
    logic [PC_W-1:0] r;
    r = s;
    if (k == KIND_TRAP) begin
      r[MSTATUS_MPIE] = s[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
    end else begin
      r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
    end
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Vectored mode only applies to interrupts; modes 10/11 fall back to direct.
  function automatic logic [PC_W-1:0] trap_target(logic [PC_W-1:0] tvec, logic [PC_W-1:0] cause);
    logic [PC_W-1:0] base;
    base = {tvec[PC_W-1:2], 2'b00};
    if (tvec[1:0] == 2'b01 && cause[PC_W-1])
      return base + {{(PC_W-6){1'b0}}, cause[3:0], 2'b00};
    return base;
  endfunction

  // NOTE: state and outputs are registers, so only non-blocking assignments here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      kind_q         <= KIND_TRAP;
      epc_q          <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      status_q       <= '0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      csr_req        <= 1'b0;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          kind_q    <= acc_kind;
          epc_q     <= acc_epc;
          cause_q   <= acc_cause;
          tval_q    <= acc_tval;
          stall     <= 1'b1;
          csr_req   <= 1'b1;
          csr_we    <= 1'b0;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= '0;
          state     <= RD_STATUS;
        end
        RD_STATUS: if (csr_ack) begin
          status_q <= next_status(kind_q, csr_rdata);
          csr_we   <= 1'b1;
          if (kind_q == KIND_MRET) begin
            csr_addr  <= CSR_MSTATUS;
            csr_wdata <= next_status(kind_q, csr_rdata);
            state     <= WR_STATUS;
          end else begin
            csr_addr  <= CSR_MEPC;
            csr_wdata <= epc_q;
            state     <= WR_EPC;
          end
        end
        WR_EPC: if (csr_ack) begin
          csr_addr  <= CSR_MCAUSE;
          csr_wdata <= cause_q;
          state     <= WR_CAUSE;
        end
        WR_CAUSE: if (csr_ack) begin
          csr_addr  <= CSR_MTVAL;
          csr_wdata <= tval_q;
          state     <= WR_TVAL;
        end
        WR_TVAL: if (csr_ack) begin
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= status_q;
          state     <= WR_STATUS;
        end
        WR_STATUS: if (csr_ack) begin
          csr_we    <= 1'b0;
          csr_wdata <= '0;
          if (kind_q == KIND_MRET) begin
            csr_addr <= CSR_MEPC;
            state    <= RD_EPC;
          end else begin
            csr_addr <= CSR_MTVEC;
            state    <= RD_TVEC;
          end
        end
        RD_TVEC: if (csr_ack) begin
          redirect_pc    <= trap_target(csr_rdata, cause_q);
          redirect_valid <= 1'b1;
          csr_req        <= 1'b0;
          csr_addr       <= '0;
          state          <= REDIRECT;
        end
        RD_EPC: if (csr_ack) begin
          redirect_pc    <= csr_rdata;
          redirect_valid <= 1'b1;
          csr_req        <= 1'b0;
          csr_addr       <= '0;
          state          <= REDIRECT;
        end
        REDIRECT: begin
          stall <= 1'b0;
          state <= IDLE;
        end
        default: begin
          stall   <= 1'b0;
          csr_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
